// File: rtl/inv_shift_rows_stream_if.sv
// Column-stream bundle for the (Inv)ShiftRows stage: input and output
// valid/ready handshakes plus output column tagging.
interface inv_shift_rows_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_col;
  logic        out_last;

  // The block under test takes the slave view; the environment drives as master.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_col,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_col,
    input  out_last
  );
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Streamed AES (Inv)ShiftRows: buffers one 4x4 state per bank in a two-bank
// ping-pong store and emits the row-rotated state one column per cycle.
module inv_shift_rows_stream #(
  parameter bit INVERSE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  inv_shift_rows_stream_if.slave        bus
);

  logic [31:0] r_mem [2][4];
  logic        r_wr_bank, r_rd_bank;
  logic [1:0]  r_wr_col, r_rd_col;
  logic [1:0]  r_full;

  logic        w_wr_bank_d, w_rd_bank_d;
  logic [1:0]  w_wr_col_d, w_rd_col_d;
  logic [1:0]  w_full_d;
  logic        w_in_ready, w_out_valid;
  logic        w_in_fire, w_out_fire;
  logic [31:0] w_out_data;

  // Handshake flags come from registers only, so no valid->ready combinational path.
  assign w_in_ready  = !r_full[r_wr_bank];
  assign w_out_valid = r_full[r_rd_bank];
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_col   = r_rd_col;
  assign bus.out_last  = w_out_valid && (r_rd_col == 2'd3);

  always_comb begin
    w_wr_bank_d = r_wr_bank;
    w_rd_bank_d = r_rd_bank;
    w_wr_col_d  = r_wr_col;
    w_rd_col_d  = r_rd_col;
    w_full_d    = r_full;
    if (w_in_fire) begin
      w_wr_col_d = r_wr_col + 2'd1;
      if (r_wr_col == 2'd3) begin
        w_full_d[r_wr_bank] = 1'b1;
        w_wr_bank_d         = !r_wr_bank;
      end
    end
    // Set and clear always target different banks: a full bank cannot be written.
    if (w_out_fire) begin
      w_rd_col_d = r_rd_col + 2'd1;
      if (r_rd_col == 2'd3) begin
        w_full_d[r_rd_bank] = 1'b0;
        w_rd_bank_d         = !r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_col  <= 2'd0;
      r_rd_col  <= 2'd0;
      r_full    <= 2'b00;
    end else begin
      r_wr_bank <= w_wr_bank_d;
      r_rd_bank <= w_rd_bank_d;
      r_wr_col  <= w_wr_col_d;
      r_rd_col  <= w_rd_col_d;
      r_full    <= w_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wr_bank][r_wr_col] <= bus.in_data;
    end
  end

  // Row r of the output column comes from stored column rd_col -/+ r.
  always_comb begin
    logic [1:0] w_src;
    w_src      = 2'd0;
    w_out_data = 32'd0;
    for (int r = 0; r < 4; r++) begin
      w_src = INVERSE ? (r_rd_col - 2'(r)) : (r_rd_col + 2'(r));
      w_out_data[24-8*r +: 8] = r_mem[r_rd_bank][w_src][24-8*r +: 8];
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed and randomised checks of the streamed (Inv)ShiftRows block,
// with an INVERSE=1 and an INVERSE=0 instance side by side.
module tb_inv_shift_rows_stream;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  inv_shift_rows_stream_if bi ();
  inv_shift_rows_stream_if bf ();

  inv_shift_rows_stream #(.INVERSE(1'b1)) u_inv (.clk(clk), .rst(rst), .bus(bi));
  inv_shift_rows_stream #(.INVERSE(1'b0)) u_fwd (.clk(clk), .rst(rst), .bus(bf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference permutation; col j of a state lives at st[32*j +: 32].
  function automatic logic [31:0] perm(input logic [127:0] st, input int c, input bit inv);
    logic [31:0] v;
    int j;
    v = '0;
    for (int r = 0; r < 4; r++) begin
      j = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
      v[24-8*r +: 8] = st[32*j + 24 - 8*r +: 8];
    end
    return v;
  endfunction

  // Drives the same state into both instances and checks both result streams.
  task automatic run_pair(input logic [127:0] din, input logic [127:0] exp_i,
                          input logic [127:0] exp_f, input string tag);
    logic [1:0] cc;
    bi.out_ready = 1'b1;
    bf.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bi.in_valid = 1'b1; bi.in_data = din[32*i +: 32];
      bf.in_valid = 1'b1; bf.in_data = din[32*i +: 32];
      n_vec++;
      if ({bi.in_ready, bi.out_valid, bf.in_ready, bf.out_valid} !== 4'b1010) begin
        n_err++;
        $display("FAIL %s fill col %0d: rdy/vld inv=%b%b fwd=%b%b, required 1010", tag, i,
                 bi.in_ready, bi.out_valid, bf.in_ready, bf.out_valid);
      end
      tick();
    end
    bi.in_valid = 1'b0;
    bf.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cc = 2'(c);
      n_vec++;
      if ({bi.out_valid, bi.out_col, bi.out_last, bi.out_data} !==
          {1'b1, cc, (c == 3), exp_i[32*c +: 32]}) begin
        n_err++;
        $display("FAIL %s inv col %0d: vld=%b col=%0d last=%b data=%h, required 1 %0d %b %h",
                 tag, c, bi.out_valid, bi.out_col, bi.out_last, bi.out_data, c, (c == 3),
                 exp_i[32*c +: 32]);
      end
      n_vec++;
      if ({bf.out_valid, bf.out_col, bf.out_last, bf.out_data} !==
          {1'b1, cc, (c == 3), exp_f[32*c +: 32]}) begin
        n_err++;
        $display("FAIL %s fwd col %0d: vld=%b col=%0d last=%b data=%h, required 1 %0d %b %h",
                 tag, c, bf.out_valid, bf.out_col, bf.out_last, bf.out_data, c, (c == 3),
                 exp_f[32*c +: 32]);
      end
      tick();
    end
    n_vec++;
    if ({bi.out_valid, bf.out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL %s drained: out_valid inv=%b fwd=%b, required 0 0", tag, bi.out_valid,
               bf.out_valid);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({bi.in_ready, bi.out_valid, bi.out_col, bi.out_last} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset inv: rdy=%b vld=%b col=%0d last=%b, required 1 0 0 0",
               bi.in_ready, bi.out_valid, bi.out_col, bi.out_last);
    end
    n_vec++;
    if ({bf.in_ready, bf.out_valid, bf.out_col, bf.out_last} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset fwd: rdy=%b vld=%b col=%0d last=%b, required 1 0 0 0",
               bf.in_ready, bf.out_valid, bf.out_col, bf.out_last);
    end
  endtask

  // Inverse and forward on the same state, plus fwd(fwd(x)) rotating rows 1/3 by two.
  task automatic test_basic();
    run_pair({32'h03132333, 32'h02122232, 32'h01112131, 32'h00102030},
             {32'h03122130, 32'h02112033, 32'h01102332, 32'h00132231},
             {32'h03102132, 32'h02132031, 32'h01122330, 32'h00112233}, "basic");
  endtask

  task automatic test_round_trip();
    run_pair({32'h03102132, 32'h02132031, 32'h01122330, 32'h00112233},
             {32'h03132333, 32'h02122232, 32'h01112131, 32'h00102030},
             {32'h03112331, 32'h02102230, 32'h01132133, 32'h00122032}, "roundtrip");
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [3];
    int oc;
    oc = 0;
    for (int s = 0; s < 3; s++) st[s] = {$urandom, $urandom, $urandom, $urandom};
    bi.out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      bi.in_valid = (k < 12);
      bi.in_data  = (k < 12) ? st[k/4][32*(k%4) +: 32] : 32'd0;
      n_vec++;
      if (bi.in_ready !== 1'b1 || bi.out_valid !== (k >= 4 && k < 16)) begin
        n_err++;
        $display("FAIL b2b cycle %0d: rdy=%b vld=%b, required 1 %b", k, bi.in_ready,
                 bi.out_valid, (k >= 4 && k < 16));
      end
      if (bi.out_valid === 1'b1) begin
        n_vec++;
        if ({bi.out_data, bi.out_col, bi.out_last} !==
            {perm(st[oc/4], oc % 4, 1'b1), 2'(oc % 4), (oc % 4 == 3)}) begin
          n_err++;
          $display("FAIL b2b out %0d: data=%h col=%0d last=%b, required %h %0d %b", oc,
                   bi.out_data, bi.out_col, bi.out_last, perm(st[oc/4], oc % 4, 1'b1),
                   oc % 4, (oc % 4 == 3));
        end
        oc++;
      end
      tick();
    end
    bi.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] st [2];
    for (int s = 0; s < 2; s++) st[s] = {$urandom, $urandom, $urandom, $urandom};
    bi.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bi.in_valid = 1'b1;
      bi.in_data  = st[k/4][32*(k%4) +: 32];
      n_vec++;
      if (bi.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL bp fill %0d: in_ready=%b, required 1", k, bi.in_ready);
      end
      tick();
    end
    bi.in_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      n_vec++;
      if ({bi.in_ready, bi.out_valid, bi.out_col, bi.out_data} !==
          {1'b0, 1'b1, 2'd0, perm(st[0], 0, 1'b1)}) begin
        n_err++;
        $display("FAIL bp stall %0d: rdy=%b vld=%b col=%0d data=%h, required 0 1 0 %h", h,
                 bi.in_ready, bi.out_valid, bi.out_col, bi.out_data, perm(st[0], 0, 1'b1));
      end
      tick();
    end
    bi.out_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      n_vec++;
      if ({bi.in_ready, bi.out_valid, bi.out_col, bi.out_data} !==
          {(o >= 4), 1'b1, 2'(o % 4), perm(st[o/4], o % 4, 1'b1)}) begin
        n_err++;
        $display("FAIL bp drain %0d: rdy=%b vld=%b col=%0d data=%h, required %b 1 %0d %h", o,
                 bi.in_ready, bi.out_valid, bi.out_col, bi.out_data, (o >= 4), o % 4,
                 perm(st[o/4], o % 4, 1'b1));
      end
      tick();
    end
    n_vec++;
    if ({bi.in_ready, bi.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp end: rdy=%b vld=%b, required 1 0", bi.in_ready, bi.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] junk [2];
    junk[0] = 32'hDEADBEEF;
    junk[1] = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      bi.in_valid = 1'b1; bi.in_data = junk[k];
      bf.in_valid = 1'b1; bf.in_data = junk[k];
      tick();
    end
    bi.in_valid = 1'b0;
    bf.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({bi.in_ready, bi.out_valid, bf.in_ready, bf.out_valid} !== 4'b1010) begin
      n_err++;
      $display("FAIL midreset flags: inv=%b%b fwd=%b%b, required 1010", bi.in_ready,
               bi.out_valid, bf.in_ready, bf.out_valid);
    end
    run_pair({32'h03132333, 32'h02122232, 32'h01112131, 32'h00102030},
             {32'h03122130, 32'h02112033, 32'h01102332, 32'h00132231},
             {32'h03102132, 32'h02132031, 32'h01122330, 32'h00112233}, "midreset");
  endtask

  task automatic test_random();
    logic [31:0]  exp_q [$];
    logic [31:0]  e;
    logic [127:0] cur;
    logic         in_fire, out_fire;
    int in_cnt, out_cnt, cyc;
    in_cnt  = 0;
    out_cnt = 0;
    cyc     = 0;
    cur     = '0;
    bi.in_valid = 1'b0;
    while (out_cnt < 800 && cyc < 20000) begin
      if (!bi.in_valid && in_cnt < 800 && $urandom_range(3) != 0) begin
        bi.in_valid = 1'b1;
        bi.in_data  = $urandom;
      end
      bi.out_ready = ($urandom_range(3) != 0);
      in_fire  = bi.in_valid && bi.in_ready;
      out_fire = bi.out_valid && bi.out_ready;
      if (out_fire) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand spurious out %0d: data=%h, required no output", out_cnt,
                   bi.out_data);
        end else begin
          e = exp_q.pop_front();
          if ({bi.out_data, bi.out_col, bi.out_last} !==
              {e, 2'(out_cnt % 4), (out_cnt % 4 == 3)}) begin
            n_err++;
            $display("FAIL rand out %0d: data=%h col=%0d last=%b, required %h %0d %b",
                     out_cnt, bi.out_data, bi.out_col, bi.out_last, e, out_cnt % 4,
                     (out_cnt % 4 == 3));
          end
        end
        out_cnt++;
      end
      if (in_fire) begin
        cur[32*(in_cnt % 4) +: 32] = bi.in_data;
        in_cnt++;
        if (in_cnt % 4 == 0) begin
          for (int c = 0; c < 4; c++) exp_q.push_back(perm(cur, c, 1'b1));
        end
      end
      tick();
      cyc++;
      if (in_fire) bi.in_valid = 1'b0;
    end
    bi.in_valid = 1'b0;
    n_vec++;
    if (out_cnt != 800 || in_cnt != 800) begin
      n_err++;
      $display("FAIL rand count: in=%0d out=%0d after %0d cycles, required 800 800", in_cnt,
               out_cnt, cyc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bi.in_valid = 1'b0; bi.in_data = '0; bi.out_ready = 1'b1;
    bf.in_valid = 1'b0; bf.in_data = '0; bf.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_round_trip();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
